// File: rtl/ring_osc_trim_seq_pkg.sv
// Shared types and the level-to-trim encoding used by the sequencer,
// its encoder and any trim checker.
package ring_osc_trim_seq_pkg;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RAMP  = 2'd2
    } state_t;

    // Primary stages fill first; secondary stages only carry the excess above nStages.
    function automatic logic encodeTrimBit(input int nStages, input int level, input int idx);
        if (idx < nStages) begin
            return (idx < level);
        end
        return ((idx - nStages) < (level - nStages));
    endfunction

endpackage

// File: rtl/ring_osc_trim_seq_if.sv
// Target-level request channel between a trim controller and the sequencer.
interface ring_osc_trim_seq_if #(
    parameter int NSTAGES = 13,
    parameter int DWELL_W = 8
);
    localparam int LW = $clog2(2*NSTAGES+1);

    logic               tgt_valid;
    logic               tgt_ready;
    logic [LW-1:0]      tgt_level;
    logic               tgt_direct;
    logic [DWELL_W-1:0] dwell;

    modport master (
        output tgt_valid, tgt_level, tgt_direct, dwell,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid, tgt_level, tgt_direct, dwell,
        output tgt_ready
    );

endinterface

// File: rtl/ring_osc_trim_seq_enc.sv
// Combinational thermometer encoder from trim level to the split
// primary/secondary trim vector.
module ring_osc_trim_enc
    import ring_osc_trim_seq_pkg::*;
#(
    parameter int NSTAGES = 13,
    parameter int LW      = $clog2(2*NSTAGES+1)
) (
    input  logic [LW-1:0]        i_level,
    output logic [2*NSTAGES-1:0] o_trim
);

    always_comb begin
        o_trim = '0;
        for (int k = 0; k < 2*NSTAGES; k++) begin
            o_trim[k] = encodeTrimBit(NSTAGES, int'(i_level), k);
        end
    end

endmodule

// File: rtl/ring_osc_trim_seq.sv
// Ring-oscillator trim sequencer: holds the oscillator in reset after power-up,
// then applies requested trim levels either directly or one stage at a time.
module ring_osc_trim_seq
    import ring_osc_trim_seq_pkg::*;
#(
    parameter int NSTAGES      = 13,
    parameter int DWELL_W      = 8,
    parameter int START_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 resetb,
    ring_osc_trim_seq_if.slave                   req,
    output logic                                 osc_reset,
    output logic [2*NSTAGES-1:0]                 trim,
    output logic [$clog2(2*NSTAGES+1)-1:0]       level,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 clamped
);

    localparam int              LW         = $clog2(2*NSTAGES+1);
    localparam int              SCW        = $clog2(START_CYCLES+1);
    localparam logic [LW-1:0]   MAX_LEVEL  = LW'(2*NSTAGES);
    localparam logic [SCW-1:0]  START_LAST = SCW'(START_CYCLES-1);

    state_t               r_state, w_nextState;
    logic [SCW-1:0]       r_startCnt, w_nextStartCnt;
    logic [DWELL_W-1:0]   r_dwellCnt, w_nextDwellCnt;
    logic [DWELL_W-1:0]   r_dwell, w_nextDwell;
    logic [LW-1:0]        r_level, w_nextLevel;
    logic [LW-1:0]        r_target, w_nextTarget;
    logic [LW-1:0]        w_reqLevel;
    logic                 r_done, w_nextDone;
    logic                 r_busy;
    logic                 r_clamped, w_nextClamped;
    logic [2*NSTAGES-1:0] r_trim, w_nextTrim;
    logic                 w_accept, w_overRange;

    assign w_overRange   = (req.tgt_level > MAX_LEVEL);
    assign w_reqLevel    = w_overRange ? MAX_LEVEL : req.tgt_level;
    assign w_accept      = req.tgt_valid && (r_state == ST_IDLE);
    assign req.tgt_ready = (r_state == ST_IDLE);
    assign osc_reset     = (r_state == ST_START);

    always_comb begin
        w_nextState    = r_state;
        w_nextStartCnt = r_startCnt;
        w_nextDwellCnt = r_dwellCnt;
        w_nextDwell    = r_dwell;
        w_nextLevel    = r_level;
        w_nextTarget   = r_target;
        w_nextDone     = 1'b0;
        w_nextClamped  = r_clamped;
        case (r_state)
            ST_START: begin
                if (r_startCnt == START_LAST) begin
                    w_nextState    = ST_IDLE;
                    w_nextStartCnt = '0;
                end else begin
                    w_nextStartCnt = r_startCnt + SCW'(1);
                end
            end
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextTarget  = w_reqLevel;
                    w_nextDwell   = req.dwell;
                    w_nextClamped = r_clamped | w_overRange;
                    if (req.tgt_direct) begin
                        w_nextLevel = w_reqLevel;
                        w_nextDone  = 1'b1;
                    end else if (w_reqLevel == r_level) begin
                        w_nextDone = 1'b1;
                    end else begin
                        w_nextState    = ST_RAMP;
                        w_nextDwellCnt = req.dwell;
                    end
                end
            end
            ST_RAMP: begin
                // One stage per dwell expiry keeps every trim change to a single bit.
                if (r_dwellCnt == '0) begin
                    w_nextDwellCnt = r_dwell;
                    w_nextLevel    = (r_target > r_level) ? (r_level + LW'(1)) : (r_level - LW'(1));
                    if (w_nextLevel == r_target) begin
                        w_nextDone  = 1'b1;
                        w_nextState = ST_IDLE;
                    end
                end else begin
                    w_nextDwellCnt = r_dwellCnt - DWELL_W'(1);
                end
            end
            default: begin
                w_nextState = ST_START;
            end
        endcase
    end

    ring_osc_trim_enc #(
        .NSTAGES (NSTAGES),
        .LW      (LW)
    ) u_enc (
        .i_level (w_nextLevel),
        .o_trim  (w_nextTrim)
    );

    // Trim is registered from the encoded next level so it never shows a transient code.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state    <= ST_START;
            r_startCnt <= '0;
            r_dwellCnt <= '0;
            r_dwell    <= '0;
            r_level    <= '0;
            r_target   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_clamped  <= 1'b0;
            r_trim     <= '0;
        end else begin
            r_state    <= w_nextState;
            r_startCnt <= w_nextStartCnt;
            r_dwellCnt <= w_nextDwellCnt;
            r_dwell    <= w_nextDwell;
            r_level    <= w_nextLevel;
            r_target   <= w_nextTarget;
            r_done     <= w_nextDone;
            r_busy     <= (w_nextState != ST_IDLE);
            r_clamped  <= w_nextClamped;
            r_trim     <= w_nextTrim;
        end
    end

    assign trim    = r_trim;
    assign level   = r_level;
    assign busy    = r_busy;
    assign done    = r_done;
    assign clamped = r_clamped;

endmodule

// File: tb/tb_ring_osc_trim_seq.sv
// Directed self-checking bench for ring_osc_trim_seq with default parameters.
module tb_ring_osc_trim_seq;

    logic        clk;
    logic        resetb;
    logic        osc_reset;
    logic [25:0] trim;
    logic [4:0]  level;
    logic        busy;
    logic        done;
    logic        clamped;

    int errors = 0;
    int checks = 0;

    ring_osc_trim_seq_if #(.NSTAGES(13), .DWELL_W(8)) reqIf ();

    ring_osc_trim_seq #(
        .NSTAGES      (13),
        .DWELL_W      (8),
        .START_CYCLES (16)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .req       (reqIf),
        .osc_reset (osc_reset),
        .trim      (trim),
        .level     (level),
        .busy      (busy),
        .done      (done),
        .clamped   (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request for a single rising edge; returns 1ns after that edge.
    task automatic applyStimulus(input logic [4:0] lvl, input logic direct, input logic [7:0] dw);
        @(negedge clk);
        reqIf.tgt_valid  = 1'b1;
        reqIf.tgt_level  = lvl;
        reqIf.tgt_direct = direct;
        reqIf.dwell      = dw;
        @(posedge clk);
        #1;
        reqIf.tgt_valid = 1'b0;
    endtask

    // Counts rising edges after reset release until osc_reset drops (bounded).
    task automatic countStart(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!osc_reset) break;
        end
    endtask

    task automatic test_reset;
        int n;
        resetb = 1'b0;
        reqIf.tgt_valid = 1'b0; reqIf.tgt_level = '0; reqIf.tgt_direct = 1'b0; reqIf.dwell = '0;
        repeat (2) @(negedge clk);
        checks++; if (trim !== 26'h0 || level !== 5'd0) begin errors++; $display("[TB] FAIL reset_trim got trim=%h level=%0d exp 0/0", trim, level); end
        checks++; if (osc_reset !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_osc got osc_reset=%b busy=%b exp 1/1", osc_reset, busy); end
        checks++; if (reqIf.tgt_ready !== 1'b0 || done !== 1'b0 || clamped !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags got ready=%b done=%b clamped=%b exp 0/0/0", reqIf.tgt_ready, done, clamped); end
        resetb = 1'b1;
        countStart(n);
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL start_len got=%0d exp=16", n); end
        checks++; if (reqIf.tgt_ready !== 1'b1 || busy !== 1'b0 || trim !== 26'h0) begin errors++; $display("[TB] FAIL start_exit got ready=%b busy=%b trim=%h exp 1/0/0", reqIf.tgt_ready, busy, trim); end
    endtask

    task automatic test_ramp_up;
        logic [25:0] prevTrim;
        int expLevel;
        int doneCount = 0;
        applyStimulus(5'd20, 1'b0, 8'd3);
        checks++; if (busy !== 1'b1 || reqIf.tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL up_enter got busy=%b ready=%b exp 1/0", busy, reqIf.tgt_ready); end
        prevTrim = trim;
        for (int c = 1; c <= 84; c++) begin
            @(posedge clk);
            #1;
            expLevel = (c / 4 > 20) ? 20 : c / 4;
            checks++; if (level !== 5'(expLevel)) begin errors++; $display("[TB] FAIL up_level c=%0d got=%0d exp=%0d", c, level, expLevel); end
            if (trim !== prevTrim) begin
                checks++; if ($countones(trim ^ prevTrim) != 1) begin errors++; $display("[TB] FAIL up_onebit c=%0d got=%h prev=%h exp one toggle", c, trim, prevTrim); end
            end
            checks++; if (done !== (c == 80)) begin errors++; $display("[TB] FAIL up_done c=%0d got=%b exp=%b", c, done, (c == 80)); end
            if (done) doneCount++;
            prevTrim = trim;
        end
        checks++; if (trim !== 26'h00FFFFF) begin errors++; $display("[TB] FAIL up_final got=%h exp=00fffff", trim); end
        checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL up_done_count got=%0d exp=1", doneCount); end
        checks++; if (reqIf.tgt_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL up_idle got ready=%b busy=%b exp 1/0", reqIf.tgt_ready, busy); end
    endtask

    task automatic test_ramp_down;
        logic [25:0] prevTrim;
        int expLevel;
        int doneCount = 0;
        applyStimulus(5'd5, 1'b0, 8'd0);
        prevTrim = trim;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk);
            #1;
            expLevel = (c <= 15) ? 20 - c : 5;
            checks++; if (level !== 5'(expLevel)) begin errors++; $display("[TB] FAIL down_level c=%0d got=%0d exp=%0d", c, level, expLevel); end
            if (c <= 7) begin
                checks++; if ($countones(trim ^ prevTrim) != 1 || ((trim ^ prevTrim) & 26'h0001FFF) != 26'h0) begin
                    errors++; $display("[TB] FAIL down_secondary c=%0d got=%h prev=%h exp one secondary bit cleared", c, trim, prevTrim);
                end
            end
            checks++; if (done !== (c == 15)) begin errors++; $display("[TB] FAIL down_done c=%0d got=%b exp=%b", c, done, (c == 15)); end
            if (done) doneCount++;
            prevTrim = trim;
        end
        checks++; if (trim !== 26'h000001F) begin errors++; $display("[TB] FAIL down_final got=%h exp=000001f", trim); end
        checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL down_done_count got=%0d exp=1", doneCount); end
    endtask

    task automatic test_direct;
        applyStimulus(5'd26, 1'b1, 8'd0);
        checks++; if (trim !== 26'h3FFFFFF || level !== 5'd26) begin errors++; $display("[TB] FAIL direct26 got trim=%h level=%0d exp 3ffffff/26", trim, level); end
        checks++; if (done !== 1'b1 || reqIf.tgt_ready !== 1'b1 || clamped !== 1'b0) begin errors++; $display("[TB] FAIL direct26_flags got done=%b ready=%b clamped=%b exp 1/1/0", done, reqIf.tgt_ready, clamped); end
        applyStimulus(5'd30, 1'b1, 8'd0);
        checks++; if (clamped !== 1'b1 || level !== 5'd26 || trim !== 26'h3FFFFFF) begin errors++; $display("[TB] FAIL clamp30 got clamped=%b level=%0d trim=%h exp 1/26/3ffffff", clamped, level, trim); end
        // Back-to-back direct requests on consecutive edges: each lands, last wins.
        @(negedge clk);
        reqIf.tgt_valid = 1'b1; reqIf.tgt_direct = 1'b1; reqIf.tgt_level = 5'd3;
        @(posedge clk); #1;
        checks++; if (level !== 5'd3 || trim !== 26'h0000007) begin errors++; $display("[TB] FAIL b2b_first got level=%0d trim=%h exp 3/0000007", level, trim); end
        reqIf.tgt_level = 5'd7;
        @(posedge clk); #1;
        reqIf.tgt_valid = 1'b0;
        checks++; if (level !== 5'd7 || trim !== 26'h000007F || done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_last got level=%0d trim=%h done=%b exp 7/000007f/1", level, trim, done); end
        // Ramp request to the current level completes immediately without entering RAMP.
        applyStimulus(5'd7, 1'b0, 8'd5);
        checks++; if (done !== 1'b1 || busy !== 1'b0 || reqIf.tgt_ready !== 1'b1 || level !== 5'd7) begin
            errors++; $display("[TB] FAIL ramp_equal got done=%b busy=%b ready=%b level=%0d exp 1/0/1/7", done, busy, reqIf.tgt_ready, level);
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL ramp_equal_pulse got done=%b exp 0", done); end
    endtask

    task automatic test_mid_reset;
        int n;
        applyStimulus(5'd0, 1'b1, 8'd0);
        applyStimulus(5'd15, 1'b0, 8'd1);
        n = 0;
        while (level !== 5'd5 && n < 60) begin @(posedge clk); #1; n++; end
        checks++; if (level !== 5'd5) begin errors++; $display("[TB] FAIL wait_level5 got=%0d exp=5", level); end
        @(negedge clk);
        reqIf.tgt_valid = 1'b1; reqIf.tgt_direct = 1'b1; reqIf.tgt_level = 5'd2;
        #1;
        checks++; if (reqIf.tgt_ready !== 1'b0) begin errors++; $display("[TB] FAIL ramp_ready got=%b exp=0", reqIf.tgt_ready); end
        @(posedge clk); #1;
        reqIf.tgt_valid = 1'b0;
        checks++; if (!(level === 5'd5 || level === 5'd6) || busy !== 1'b1) begin errors++; $display("[TB] FAIL ramp_ignore got level=%0d busy=%b exp 5or6/1", level, busy); end
        n = 0;
        while (level !== 5'd9 && n < 60) begin @(posedge clk); #1; n++; end
        checks++; if (level !== 5'd9) begin errors++; $display("[TB] FAIL wait_level9 got=%0d exp=9", level); end
        #1;
        resetb = 1'b0;
        #1;
        checks++; if (trim !== 26'h0 || level !== 5'd0 || osc_reset !== 1'b1) begin errors++; $display("[TB] FAIL async_reset got trim=%h level=%0d osc=%b exp 0/0/1", trim, level, osc_reset); end
        checks++; if (busy !== 1'b1 || reqIf.tgt_ready !== 1'b0 || done !== 1'b0 || clamped !== 1'b0) begin
            errors++; $display("[TB] FAIL async_flags got busy=%b ready=%b done=%b clamped=%b exp 1/0/0/0", busy, reqIf.tgt_ready, done, clamped);
        end
        @(negedge clk);
        resetb = 1'b1;
        countStart(n);
        checks++; if (n !== 16) begin errors++; $display("[TB] FAIL restart_len got=%0d exp=16", n); end
        checks++; if (reqIf.tgt_ready !== 1'b1 || trim !== 26'h0 || level !== 5'd0) begin errors++; $display("[TB] FAIL restart_idle got ready=%b trim=%h level=%0d exp 1/0/0", reqIf.tgt_ready, trim, level); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_direct();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ring_osc_trim_seq.md
RING_OSC_TRIM_SEQ -- requirements
Module: ring_osc_trim_seq

Interface
REQ-001 Parameter NSTAGES, default 13: number of ring-oscillator delay stages; the trim vector is 2*NSTAGES bits.
REQ-002 Parameter DWELL_W, default 8: width of the dwell-count input.
REQ-003 Parameter START_CYCLES, default 16: clk cycles for which osc_reset stays asserted after reset release.
REQ-004 Derived constant LW = clog2(2*NSTAGES+1): width of the level fields.
REQ-005 clk  in  1  sole clock; every flop is rising-edge.
REQ-006 resetb  in  1  asynchronous, active-low reset.
REQ-007 tgt_valid  in  1  new target-level request.
REQ-008 tgt_ready  out  1  request accepted when tgt_valid && tgt_ready at a rising clk edge.
REQ-009 tgt_level  in  LW  requested trim level, 0..2*NSTAGES.
REQ-010 tgt_direct  in  1  sampled with the request; 1 = jump straight to the target, 0 = ramp one bit at a time.
REQ-011 dwell  in  DWELL_W  number of clk cycles held between ramp steps; sampled at acceptance.
REQ-012 osc_reset  out  1  drives the oscillator start-stage reset.
REQ-013 trim  out  2*NSTAGES  trim vector: bits [NSTAGES-1:0] are primary, bits [2*NSTAGES-1:NSTAGES] are secondary.
REQ-014 level  out  LW  current applied level.
REQ-015 busy  out  1  high while in START or RAMP.
REQ-016 done  out  1  one-cycle pulse when level first equals the accepted target.
REQ-017 clamped  out  1  sticky flag; set when a request exceeds 2*NSTAGES, cleared only by reset.

Function
REQ-018 Encoding, where L is the level:
- trim[k] = 1 for k < min(L, NSTAGES).
- trim[NSTAGES+k] = 1 for k < L-NSTAGES, when L > NSTAGES.
- All other bits are 0.
REQ-019 trim, level, busy and done shall be registered outputs; trim shall always equal the encoding of level (no intermediate codes).
REQ-020 FSM states: START, IDLE, RAMP.
REQ-021 START: osc_reset=1, tgt_ready=0, a counter runs START_CYCLES cycles, then the FSM enters IDLE and osc_reset=0.
REQ-022 IDLE: tgt_ready=1; on acceptance, tgt_level is clamped to 2*NSTAGES (setting clamped if it exceeds that) and latched as the target.
REQ-023 Direct acceptance: level is loaded with the target on the next edge, done pulses on that same edge, and the FSM stays in IDLE.
REQ-024 Ramp acceptance with target equal to level: done pulses on the next cycle and the FSM stays in IDLE.
REQ-025 Ramp acceptance with target different from level: the FSM enters RAMP and the dwell counter loads dwell.
REQ-026 RAMP: when the dwell counter reaches 0:
- level moves by ±1 toward the target, changing exactly one trim bit;
- the counter reloads with the latched dwell.
REQ-027 Ramp step order: upward, primary bits fill before secondary bits; downward, secondary bits clear before primary bits (this follows from REQ-018).
REQ-028 dwell=0 shall give one step per clk cycle.
REQ-029 Reaching the target in RAMP: done pulses on the cycle level becomes equal to the target, and the FSM returns to IDLE with tgt_ready=1 on the next cycle.
REQ-030 tgt_ready shall be 0 in START and RAMP; requests presented then are ignored and not queued.
REQ-031 Repeated direct requests in consecutive IDLE cycles are each accepted; the last one wins.

Reset
REQ-032 Assertion of resetb, including mid-ramp, shall asynchronously force:
- state=START, level=0, trim=0, osc_reset=1;
- busy=1, tgt_ready=0, done=0, clamped=0;
- all counters to 0.
REQ-033 After deassertion, osc_reset shall stay high for exactly START_CYCLES rising edges.

Structure
REQ-034 A shared package shall hold the state enum and an encoding function level->trim, for reuse by the trim checker.
REQ-035 The design shall use one sub-module, ring_osc_trim_enc: a combinational level-to-trim encoder, parametrised by NSTAGES.
REQ-036 The design shall be synthesizable with no latches; trim shall fan out directly to the oscillator stages.

Verification
REQ-037 Reset: release resetb -> osc_reset=1 for 16 cycles, then 0; tgt_ready=1; trim=0.
REQ-038 Ramp up: target 20, dwell 3, ramp mode ->
- 20 steps, 4 cycles apart;
- trim ends at primary all 1s and secondary bits[6:0]=1;
- exactly one trim bit toggles per step; one done pulse.
REQ-039 Ramp down from 20 to 5, dwell 0 -> the secondary bits clear first, one step per cycle; final trim=0x1F; done pulses once.
REQ-040 Direct to 26, then request 30 -> trim all 1s on the next edge; the 30 request sets clamped=1 and level stays 26.
REQ-041 resetb pulsed mid-ramp at level 9 -> trim=0 immediately (asynchronous); START repeats; a request during RAMP is shown to be ignored (tgt_ready=0).
